mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path and the load/store data path of the CPU core.
- Grants one requester at a time and drives a variable-latency memory handshake (mem_req/mem_ack).
- Returns read data and a one-cycle done pulse to the granted requester, and produces the core stall signal.
- Includes a watchdog that aborts memory transactions that are never acknowledged.

---
 rtl/mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and
// load/store. A data request wins over a fetch. A watchdog aborts a transfer that
// sees no mem_ack for TIMEOUT cycles; TIMEOUT = 0 disables it.
// Optional macro MEM_ARB_PERF_EN adds stall and completion performance counters.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic [DWIDTH-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_if_count,
    output logic [31:0]       perf_d_count
`endif
);

    localparam int unsigned   CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WdMax  = CW'(TIMEOUT);
    // Abort fires on the edge that ends the TIMEOUT-th unacknowledged cycle.
    localparam logic [CW-1:0] WdLast = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StDBusy, StIfBusy} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       wd_cnt_q, wd_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DWIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;
    logic                err_q, err_d;

    logic idle, grant_d, grant_if, ack_hit, wd_abort;

    // A requester is ignored in its own done cycle so it is not granted twice.
    assign idle     = (state_q == StIdle);
    assign grant_d  = idle & d_req & ~d_done_q;
    assign grant_if = idle & ~grant_d & if_req & ~if_done_q;
    assign ack_hit  = ~idle & mem_ack;
    // Ack has precedence over the watchdog in the same cycle.
    assign wd_abort = (TIMEOUT > 0) & ~idle & ~mem_ack & (wd_cnt_q == WdLast);

    assign stall = (if_req & ~if_done_q) | (d_req & ~d_done_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant from idle, return to idle on ack or watchdog abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StDBusy;
                end else if (grant_if) begin
                    state_d = StIfBusy;
                end
            end
            StDBusy, StIfBusy: begin
                if (ack_hit || wd_abort) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered memory-side and requester-side outputs.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_if) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            StDBusy: begin
                if (ack_hit) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (wd_abort) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    err_d     = 1'b1;
                    d_rdata_d = '0;
                end
            end
            StIfBusy: begin
                if (ack_hit) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (wd_abort) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_done_d  = 1'b1;
                    err_d      = 1'b1;
                    if_rdata_d = '0;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // Watchdog: count unacked request cycles, clear on grant, saturate at TIMEOUT.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (grant_d || grant_if) begin
            wd_cnt_d = '0;
        end else if (mem_req_q && !mem_ack && (wd_cnt_q != WdMax)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Registered outputs and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_if_q, perf_d_q;

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_if_q    <= '0;
            perf_d_q     <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, stall};
            perf_if_q    <= perf_if_q + {31'd0, if_done_q};
            perf_d_q     <= perf_d_q + {31'd0, d_done_q};
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_if_count     = perf_if_q;
    assign perf_d_count      = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory/requester model. Two instances share the
// inputs: the default watchdog (255) and a short watchdog (TIMEOUT = 4).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;

    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_done, d_done, mem_req, mem_we, stall, err;

    logic [DW-1:0] w_if_rdata, w_d_rdata, w_mem_wdata;
    logic [AW-1:0] w_mem_addr;
    logic          w_if_done, w_d_done, w_mem_req, w_mem_we, w_stall, w_err;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] p_stall, p_if, p_d, w_p_stall, w_p_if, w_p_d;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .err(err)
`ifdef MEM_ARB_PERF_EN
        , .perf_stall_cycles(p_stall), .perf_if_count(p_if), .perf_d_count(p_d)
`endif
    );

    mem_port_arbiter #(.TIMEOUT(4)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(w_if_rdata), .if_done(w_if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(w_d_rdata), .d_done(w_d_done),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(w_stall), .err(w_err)
`ifdef MEM_ARB_PERF_EN
        , .perf_stall_cycles(w_p_stall), .perf_if_count(w_p_if), .perf_d_count(w_p_d)
`endif
    );

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        checks++;
        if ({mem_req, mem_we, if_done, d_done, err} !== 5'b0) begin
            failures++;
            $display("FAIL rst_ctrl got %b exp 00000", {mem_req, mem_we, if_done, d_done, err});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL rst_mem_bus got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL rst_rdata got if=%h d=%h exp 0", if_rdata, d_rdata);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall got %b exp 0", stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_issue got req=%b addr=%h we=%b exp 1/40/0", mem_req, mem_addr, mem_we);
        end
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL fetch_stall got %b exp 1", stall);
        end
        tick();
        checks++;
        if (if_done !== 1'b0 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL fetch_wait got done=%b req=%b exp 0/1", if_done, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h2008_0005 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done got done=%b rdata=%h exp 1/20080005", if_done, if_rdata);
        end
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_release got req=%b stall=%b exp 0/0", mem_req, stall);
        end
        // if_req still high through the done cycle: must not be re-granted
        tick();
        checks++;
        if (if_done !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_no_regrant got done=%b req=%b exp 0/0", if_done, mem_req);
        end
        if_req = 1'b0;
    endtask

    task automatic test_priority();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h44;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
            mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL prio_store got req=%b we=%b addr=%h wdata=%h exp 1/1/100/deadbeef",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (d_done !== 1'b1 || if_done !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL prio_store_done got d=%b if=%b req=%b exp 1/0/0", d_done, if_done, mem_req);
        end
        checks++;
        if (d_rdata !== 32'h0 || if_rdata !== 32'h2008_0005) begin
            failures++;
            $display("FAIL prio_rdata_hold got d=%h if=%h exp 0/20080005", d_rdata, if_rdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44) begin
            failures++;
            $display("FAIL prio_fetch_grant got req=%b we=%b addr=%h exp 1/0/44", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h1111 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL prio_fetch_done got done=%b if=%h d=%h exp 1/1111/0", if_done, if_rdata, d_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_load_delay();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0 ||
                stall !== 1'b1 || d_done !== 1'b0) begin
                failures++;
                $display("FAIL load_wait c=%0d got req=%b addr=%h we=%b stall=%b done=%b exp 1/200/0/1/0",
                         c, mem_req, mem_addr, mem_we, stall, d_done);
            end
            if (c == 6) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end else begin
                mem_rdata = $urandom();
            end
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 32'h1234_5678 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL load_done got done=%b rdata=%h req=%b exp 1/12345678/0", d_done, d_rdata, mem_req);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (w_if_done !== 1'b1 || w_if_rdata !== 32'hA5A5_5A5A || w_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_prefetch got done=%b rdata=%h err=%b exp 1/a5a55a5a/0", w_if_done, w_if_rdata, w_err);
        end
        if_req = 1'b0;
        tick();
        // fetch that is never acknowledged
        if_req = 1'b1; if_addr = 32'h84;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (w_mem_req !== 1'b1 || w_err !== 1'b0 || w_if_done !== 1'b0) begin
                failures++;
                $display("FAIL wd_pending c=%0d got req=%b err=%b done=%b exp 1/0/0", c, w_mem_req, w_err, w_if_done);
            end
        end
        tick();
        checks++;
        if (w_err !== 1'b1 || w_if_done !== 1'b1 || w_if_rdata !== 32'h0 || w_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wd_abort got err=%b done=%b rdata=%h req=%b exp 1/1/0/0",
                     w_err, w_if_done, w_if_rdata, w_mem_req);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (w_err !== 1'b0 || w_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wd_err_pulse got err=%b req=%b exp 0/0", w_err, w_mem_req);
        end
        // ack arrives in the very cycle the count reaches TIMEOUT
        if_req = 1'b1; if_addr = 32'h88;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h88) begin
                failures++;
                $display("FAIL wd_late_wait c=%0d got req=%b addr=%h exp 1/88", c, w_mem_req, w_mem_addr);
            end
            if (c == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
            end
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (w_if_done !== 1'b1 || w_err !== 1'b0 || w_if_rdata !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL wd_ack_wins got done=%b err=%b rdata=%h exp 1/0/0badf00d",
                     w_if_done, w_err, w_if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_grant got req=%b exp 1", mem_req);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_drop got req=%b done=%b exp 0/0", mem_req, d_done);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_hold got req=%b done=%b exp 0/0", mem_req, d_done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_regrant got req=%b addr=%h done=%b exp 1/10/0", mem_req, mem_addr, d_done);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL mid_complete got done=%b rdata=%h exp 1/cafe0001", d_done, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    // Random traffic: bench plays both requesters and a word memory with random latency.
    task automatic test_random();
        logic [31:0]   mem_model [16];
        logic [31:0]   ack_data, exp_ifr, exp_dr;
        logic [AW-1:0] own_addr;
        int            lat, owner, n_if, n_d;
        int unsigned   perf_st;
        bit            ack_prev, req_prev, pend_d, pend_if, owner_we;
        bit            exp_req, exp_ifd, exp_dd, exp_st;
        do_reset();
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom();
        lat = -1; owner = 0; n_if = 0; n_d = 0; perf_st = 0;
        ack_prev = 0; req_prev = 0; pend_d = 0; pend_if = 0; owner_we = 0;
        exp_ifr = '0; exp_dr = '0; ack_data = '0; own_addr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            // completion follows the acked cycle; a new grant follows a pending idle cycle
            exp_dd  = ack_prev && (owner == 1);
            exp_ifd = ack_prev && (owner == 2);
            if (exp_ifd) begin
                exp_ifr = ack_data;
                n_if++;
            end
            if (exp_dd) begin
                n_d++;
                if (!owner_we) exp_dr = ack_data;
            end
            exp_req = ack_prev ? 1'b0 : (req_prev | pend_d | pend_if);
            checks++;
            if (d_done !== exp_dd || if_done !== exp_ifd || mem_req !== exp_req || err !== 1'b0) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got d=%b if=%b req=%b err=%b exp %b/%b/%b/0",
                         cyc, d_done, if_done, mem_req, err, exp_dd, exp_ifd, exp_req);
            end
            checks++;
            if (d_rdata !== exp_dr || if_rdata !== exp_ifr) begin
                failures++;
                $display("FAIL rand_rdata cyc=%0d got d=%h if=%h exp %h/%h", cyc, d_rdata, if_rdata, exp_dr, exp_ifr);
            end
            if (ack_prev) owner = 0;
            if (exp_req && !req_prev) begin
                if (pend_d) begin
                    owner = 1; owner_we = d_we; own_addr = d_addr;
                end else begin
                    owner = 2; owner_we = 1'b0; own_addr = if_addr;
                end
            end
            if (exp_req) begin
                checks++;
                if (mem_addr !== own_addr || mem_we !== owner_we ||
                    (owner_we && mem_wdata !== d_wdata)) begin
                    failures++;
                    $display("FAIL rand_bus cyc=%0d got addr=%h we=%b wdata=%h exp %h/%b/%h",
                             cyc, mem_addr, mem_we, mem_wdata, own_addr, owner_we, d_wdata);
                end
            end
            // memory responder
            ack_prev = 1'b0;
            if (exp_req) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                if (lat == 0) begin
                    ack_data = mem_model[own_addr[5:2]];
                    if (owner_we) mem_model[own_addr[5:2]] = d_wdata;
                    mem_ack = 1'b1; mem_rdata = ack_data; ack_prev = 1'b1; lat = -1;
                end else begin
                    lat--;
                    mem_ack = 1'b0; mem_rdata = $urandom();
                end
            end else begin
                // stray acks while idle must be ignored
                mem_ack = ($urandom_range(0, 7) == 0); mem_rdata = $urandom();
            end
            // requesters
            if (exp_dd) begin
                d_req = 1'b0;
            end else if (!d_req && cyc < 360 && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom();
            end
            if (exp_ifd) begin
                if_req = 1'b0;
            end else if (!if_req && cyc < 360 && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            pend_d   = d_req && !exp_dd;
            pend_if  = if_req && !exp_ifd;
            req_prev = exp_req;
            #1;
            exp_st = pend_d | pend_if;
            checks++;
            if (stall !== exp_st) begin
                failures++;
                $display("FAIL rand_stall cyc=%0d got %b exp %b", cyc, stall, exp_st);
            end
            perf_st += 32'(exp_st);
        end
        mem_ack = 1'b0;
        tick();
        checks++;
        if (d_req !== 1'b0 || if_req !== 1'b0) begin
            failures++;
            $display("FAIL rand_drain got d_req=%b if_req=%b exp 0/0", d_req, if_req);
        end
`ifdef MEM_ARB_PERF_EN
        checks++;
        if (p_stall !== perf_st || p_if !== 32'(n_if) || p_d !== 32'(n_d)) begin
            failures++;
            $display("FAIL perf_counts got stall=%0d if=%0d d=%0d exp %0d/%0d/%0d",
                     p_stall, p_if, p_d, perf_st, n_if, n_d);
        end
`endif
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_fetch();
        test_priority();
        test_load_delay();
        test_watchdog();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

endmodule
